pipelined_register_file: RTL and testbench



---
 rtl/pipelined_register_file_pkg.sv | 10 +
 rtl/pipelined_register_file_scoreboard.sv | 55 +++++
 rtl/pipelined_register_file.sv | 79 +++++++
 tb/tb_pipelined_register_file.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipelined_register_file_pkg.sv
// Shared sizing constants for the pipelined core's register file, its
// scoreboard and the bench that exercises them.
package pipelined_register_file_pkg;

    localparam int DATA_WIDTH_32       = 32;
    localparam int REGISTER_NUM        = 32;
    localparam int REGISTER_ADDR_WIDTH = $clog2(REGISTER_NUM);
    localparam int REGISTER_READ_PORTS = 2;

endpackage

// File: rtl/pipelined_register_file_scoreboard.sv
// register_scoreboard: one busy bit per architectural register.
// Issue reserves a destination, writeback releases it.
// Read ports look up the bits, and issue gets a WAW conflict flag.
module register_scoreboard
    import pipelined_register_file_pkg::*;
#(
    parameter int REG_NUM    = REGISTER_NUM,
    parameter int ADDR_WIDTH = REGISTER_ADDR_WIDTH,
    parameter int READ_PORTS = REGISTER_READ_PORTS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             writeEnable,
    input  logic [ADDR_WIDTH-1:0]            desRegister,
    input  logic                             reserveEnable,
    input  logic [ADDR_WIDTH-1:0]            reserveRegister,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] srcRegister,
    output logic [READ_PORTS-1:0]            portBusy,
    output logic                             reserveConflict
);

    localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(REG_NUM);

    logic [REG_NUM-1:0] busy;
    logic               desValid;
    logic               reserveValid;

    assign desValid     = (desRegister != '0) && ({1'b0, desRegister} < REG_LIMIT);
    assign reserveValid = (reserveRegister != '0) && ({1'b0, reserveRegister} < REG_LIMIT);

    // Release on writeback, then reserve, so a same-edge reserve (newer producer) wins
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (writeEnable && desValid) begin
                busy[desRegister] <= 1'b0;
            end
            if (reserveEnable && reserveValid) begin
                busy[reserveRegister] <= 1'b1;
            end
        end
    end

    assign reserveConflict = !reset && reserveEnable && reserveValid && busy[reserveRegister]
                             && !(writeEnable && (desRegister == reserveRegister));

    // Per-port lookup: register 0 and out-of-range indices never report busy
    for (genvar p = 0; p < READ_PORTS; p++) begin : g_lookup
        logic [ADDR_WIDTH-1:0] src;
        assign src         = srcRegister[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign portBusy[p] = !reset && (src != '0) && ({1'b0, src} < REG_LIMIT) && busy[src];
    end

endmodule

// File: rtl/pipelined_register_file.sv
// pipelined_register_file: N combinational read ports, one synchronous
// write port, an optional same-cycle write-to-read bypass and a scoreboard
// of pending writebacks used for RAW/WAW hazard detection at issue.
module pipelined_register_file
    import pipelined_register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_32,
    parameter int REG_NUM    = REGISTER_NUM,
    parameter int ADDR_WIDTH = $clog2(REG_NUM),
    parameter int READ_PORTS = REGISTER_READ_PORTS,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] srcRegister,
    output logic [READ_PORTS*DATA_WIDTH-1:0] readData,
    output logic [READ_PORTS-1:0]            readBusy,
    input  logic                             writeEnable,
    input  logic [ADDR_WIDTH-1:0]            desRegister,
    input  logic [DATA_WIDTH-1:0]            writeData,
    input  logic                             reserveEnable,
    input  logic [ADDR_WIDTH-1:0]            reserveRegister,
    output logic                             reserveConflict
);

    localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(REG_NUM);

    logic [DATA_WIDTH-1:0] regArray [REG_NUM];
    logic                  desValid;
    logic [READ_PORTS-1:0] portBusy;

    assign desValid = (desRegister != '0) && ({1'b0, desRegister} < REG_LIMIT);

    // Data array: cleared on reset; entry 0 is never written so it stays zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regArray[i] <= '0;
            end
        end else if (writeEnable && desValid) begin
            regArray[desRegister] <= writeData;
        end
    end

    register_scoreboard #(
        .REG_NUM   (REG_NUM),
        .ADDR_WIDTH(ADDR_WIDTH),
        .READ_PORTS(READ_PORTS)
    ) u_scoreboard (
        .clk            (clk),
        .reset          (reset),
        .writeEnable    (writeEnable),
        .desRegister    (desRegister),
        .reserveEnable  (reserveEnable),
        .reserveRegister(reserveRegister),
        .srcRegister    (srcRegister),
        .portBusy       (portBusy),
        .reserveConflict(reserveConflict)
    );

    // Per-port read mux: zero for x0/out-of-range/reset, else bypass or array
    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] src;
        logic                  srcValid;
        logic                  bypassHit;

        assign src       = srcRegister[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign srcValid  = (src != '0) && ({1'b0, src} < REG_LIMIT);
        assign bypassHit = (BYPASS != 0) && writeEnable && (desRegister == src);

        assign readData[p*DATA_WIDTH +: DATA_WIDTH] =
            (reset || !srcValid) ? '0 :
            bypassHit            ? writeData :
                                   regArray[src];

        assign readBusy[p] = portBusy[p] && !bypassHit;
    end

endmodule

// File: tb/tb_pipelined_register_file.sv
// Bench for pipelined_register_file: a bypassing and a non-bypassing instance
// share one stimulus stream and are compared every cycle against an
// array-based reference model of the register file and its pending writes.
module tb_pipelined_register_file;

    logic        clk;
    logic        reset;
    logic [9:0]  srcRegister;
    logic        writeEnable;
    logic [4:0]  desRegister;
    logic [31:0] writeData;
    logic        reserveEnable;
    logic [4:0]  reserveRegister;

    logic [63:0] readDataB, readDataN;
    logic [1:0]  readBusyB, readBusyN;
    logic        conflictB, conflictN;

    int vectors;
    int miscompares;

    logic [31:0] modelReg  [32];
    bit          modelBusy [32];

    pipelined_register_file #(.BYPASS(1)) dutBypass (
        .clk(clk), .reset(reset), .srcRegister(srcRegister),
        .readData(readDataB), .readBusy(readBusyB),
        .writeEnable(writeEnable), .desRegister(desRegister), .writeData(writeData),
        .reserveEnable(reserveEnable), .reserveRegister(reserveRegister),
        .reserveConflict(conflictB)
    );

    pipelined_register_file #(.BYPASS(0)) dutNoBypass (
        .clk(clk), .reset(reset), .srcRegister(srcRegister),
        .readData(readDataN), .readBusy(readBusyN),
        .writeEnable(writeEnable), .desRegister(desRegister), .writeData(writeData),
        .reserveEnable(reserveEnable), .reserveRegister(reserveRegister),
        .reserveConflict(conflictN)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] expectData(input logic [4:0] src, input bit bypass);
        if (reset || src == 5'd0) return 32'd0;
        if (bypass && writeEnable && desRegister == src) return writeData;
        return modelReg[src];
    endfunction

    function automatic logic [31:0] expectBusy(input logic [4:0] src, input bit bypass);
        if (reset || src == 5'd0) return 32'd0;
        if (bypass && writeEnable && desRegister == src) return 32'd0;
        return {31'd0, modelBusy[src]};
    endfunction

    function automatic logic [31:0] expectConflict();
        if (reset || !reserveEnable || reserveRegister == 5'd0) return 32'd0;
        if (writeEnable && desRegister == reserveRegister) return 32'd0;
        return {31'd0, modelBusy[reserveRegister]};
    endfunction

    task automatic checkCycle();
        for (int p = 0; p < 2; p++) begin
            logic [4:0] src;
            src = srcRegister[p*5 +: 5];
            checkOutput($sformatf("bypass.data%0d x%0d", p, src), readDataB[p*32 +: 32], expectData(src, 1'b1));
            checkOutput($sformatf("bypass.busy%0d x%0d", p, src), {31'd0, readBusyB[p]}, expectBusy(src, 1'b1));
            checkOutput($sformatf("nobypass.data%0d x%0d", p, src), readDataN[p*32 +: 32], expectData(src, 1'b0));
            checkOutput($sformatf("nobypass.busy%0d x%0d", p, src), {31'd0, readBusyN[p]}, expectBusy(src, 1'b0));
        end
        checkOutput("bypass.conflict", {31'd0, conflictB}, expectConflict());
        checkOutput("nobypass.conflict", {31'd0, conflictN}, expectConflict());
    endtask

    // Architectural effect of one clock edge: reset clears all; otherwise write releases, reserve marks pending
    task automatic updateModel();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                modelReg[i]  = 32'd0;
                modelBusy[i] = 1'b0;
            end
        end else begin
            if (writeEnable && desRegister != 5'd0) begin
                modelReg[desRegister]  = writeData;
                modelBusy[desRegister] = 1'b0;
            end
            if (reserveEnable && reserveRegister != 5'd0) begin
                modelBusy[reserveRegister] = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit we, input logic [4:0] des, input logic [31:0] wd,
                                 input bit re, input logic [4:0] res, input logic [4:0] s0, input logic [4:0] s1);
        reset           = rst;
        writeEnable     = we;
        desRegister     = des;
        writeData       = wd;
        reserveEnable   = re;
        reserveRegister = res;
        srcRegister     = {s1, s0};
        @(negedge clk);
        checkCycle();
        @(posedge clk);
        updateModel();
        #1;
    endtask

    function automatic logic [4:0] randomAddr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    // Directed scenarios followed by a randomized run
    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 32; i++) begin
            modelReg[i]  = 32'd0;
            modelBusy[i] = 1'b0;
        end
        reset = 1'b1; writeEnable = 1'b0; desRegister = '0; writeData = '0;
        reserveEnable = 1'b0; reserveRegister = '0; srcRegister = '0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 3, 4);

        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
        end

        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 1, 5'(i), 32'(i + 1), 0, 0, 5'(i), 5'(i));
            applyStimulus(0, 0, 0, 0, 0, 0, 5'(i), 5'(i));
        end

        applyStimulus(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 5);

        applyStimulus(0, 0, 0, 0, 1, 7, 7, 0);
        applyStimulus(0, 0, 0, 0, 1, 7, 7, 7);
        applyStimulus(0, 1, 7, 32'h42, 0, 0, 7, 7);
        applyStimulus(0, 0, 0, 0, 0, 0, 7, 7);

        applyStimulus(0, 1, 9, 32'h99, 1, 9, 9, 9);
        applyStimulus(0, 0, 0, 0, 1, 0, 9, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 9);

        applyStimulus(0, 1, 4, 32'h11, 1, 3, 3, 4);
        applyStimulus(1, 0, 0, 0, 0, 0, 3, 4);
        applyStimulus(0, 0, 0, 0, 0, 0, 3, 4);

        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 59) == 0,
                          $urandom_range(0, 2) != 0, randomAddr(), $urandom(),
                          $urandom_range(0, 2) != 0, randomAddr(),
                          randomAddr(), randomAddr());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
